// File: rtl/cam_capture_sched_if.sv
// Control, frame-timing and DMA handshake signals of the camera capture scheduler.
// The master modport is the scheduler itself. The slave modport is the surrounding
// register block, pixel path and DMA engine.
interface cam_capture_sched_if;
    logic        cam_confdone;
    logic        cam_dma_init_done;
    logic        trigger_capture_frame;
    logic        continuous_capture_frame;
    logic        cam_vsync;
    logic        cam_frame_end;
    logic        dma_start;
    logic        dma_ready;
    logic        dma_done;
    logic        frame_gate;
    logic        capture_busy;
    logic        timeout_err;
    logic [31:0] frames_per_second;
    logic [31:0] frames_captured;
    logic [31:0] capture_status;

    modport master (
        input  cam_confdone, cam_dma_init_done, trigger_capture_frame,
               continuous_capture_frame, cam_vsync, cam_frame_end, dma_ready, dma_done,
        output dma_start, frame_gate, capture_busy, timeout_err,
               frames_per_second, frames_captured, capture_status
    );

    modport slave (
        output cam_confdone, cam_dma_init_done, trigger_capture_frame,
               continuous_capture_frame, cam_vsync, cam_frame_end, dma_ready, dma_done,
        input  dma_start, frame_gate, capture_busy, timeout_err,
               frames_per_second, frames_captured, capture_status
    );
endinterface

// File: rtl/cam_capture_sched.sv
// Camera frame capture scheduler.
// Converts single-shot and continuous capture requests into per-frame sequencing:
// arm one DMA descriptor, wait for start-of-frame, gate pixels until end-of-frame,
// then wait for DMA completion. It also keeps the frame, drop and FPS statistics.
// Every output comes straight from a flop.
module cam_capture_sched #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned TIMEOUT_CYC = 16777215,
    parameter int unsigned TO_WIDTH    = 24
) (
    input  logic                clk,
    input  logic                resetn,
    cam_capture_sched_if.master bus
);

    typedef enum logic [2:0] {
        S_DISABLED = 3'd0,
        S_IDLE     = 3'd1,
        S_ARM      = 3'd2,
        S_WAIT_SOF = 3'd3,
        S_CAPTURE  = 3'd4,
        S_WAIT_DMA = 3'd5
    } state_t;

    // Last cycle index of the one-second FPS window.
    localparam logic [31:0]         FPS_LAST = 32'(CLK_FREQ_HZ - 1);
    // The dwell timer value seen on the TIMEOUT_CYC-th cycle in a waiting state.
    localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic                trig_d, vsync_d;
    logic                trig_rise, sof, enabled;
    logic                timed, at_limit, done_acc;
    logic [TO_WIDTH-1:0] to_cnt_q;
    logic [15:0]         drop_q;
    logic [31:0]         cap_q, win_q, fps_q, cyc_q;
    logic                dma_start_q, gate_q, busy_q, cont_q;

    assign enabled   = bus.cam_confdone & bus.cam_dma_init_done;
    assign trig_rise = bus.trigger_capture_frame & ~trig_d;
    assign sof       = bus.cam_vsync & ~vsync_d;
    assign timed     = (state_q == S_WAIT_SOF) || (state_q == S_CAPTURE) ||
                       (state_q == S_WAIT_DMA);
    assign at_limit  = timed && (to_cnt_q == TO_LAST);

    // Keep the previous trigger and vsync samples for rising-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then samples
        // pre-edge values, whatever order the simulator runs the blocks in.
        if (!resetn) begin
            trig_d  <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            trig_d  <= bus.trigger_capture_frame;
            vsync_d <= bus.cam_vsync;
        end
    end

    // Next-state logic, pending request and timeout flag.
    // Losing an enable overrides everything else. The waiting states abort on the timer.
    always_comb begin
        // NOTE: every signal gets a default first. Then no path leaves a value
        // unassigned, and no latch can be inferred.
        state_d  = state_q;
        pend_d   = pend_q;
        err_d    = err_q;
        done_acc = 1'b0;
        if (trig_rise) begin
            pend_d = 1'b1;
            err_d  = 1'b0;
        end
        if (state_q != S_DISABLED && !enabled) begin
            state_d = S_DISABLED;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_DISABLED: begin
                    if (enabled) state_d = S_IDLE;
                end
                S_IDLE: begin
                    // Starting a frame consumes the request, along with any edge in this cycle.
                    if (pend_q || bus.continuous_capture_frame) begin
                        state_d = S_ARM;
                        pend_d  = 1'b0;
                    end
                end
                S_ARM: begin
                    // Wait indefinitely for the DMA to take the descriptor.
                    if (dma_start_q && bus.dma_ready) state_d = S_WAIT_SOF;
                end
                S_WAIT_SOF: begin
                    if (sof)           state_d = S_CAPTURE;
                    else if (at_limit) state_d = S_IDLE;
                end
                S_CAPTURE: begin
                    if (bus.cam_frame_end) state_d = S_WAIT_DMA;
                    else if (at_limit)     state_d = S_IDLE;
                end
                S_WAIT_DMA: begin
                    if (bus.dma_done) begin
                        done_acc = 1'b1;
                        if (bus.continuous_capture_frame || pend_q) begin
                            state_d = S_ARM;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (at_limit) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_DISABLED;
            endcase
            // A timeout wins over a trigger edge in the same cycle, so the error is not lost.
            if (at_limit && state_d == S_IDLE && !done_acc) begin
                err_d  = 1'b1;
                pend_d = 1'b0;
            end
        end
    end

    // Hold the state, the pending request and the sticky timeout flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_DISABLED;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    // Decode the registered outputs from the state being entered, so they change with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dma_start_q <= 1'b0;
            gate_q      <= 1'b0;
            busy_q      <= 1'b0;
            cont_q      <= 1'b0;
        end else begin
            dma_start_q <= (state_d == S_ARM);
            gate_q      <= (state_d == S_CAPTURE);
            busy_q      <= (state_d != S_DISABLED) && (state_d != S_IDLE);
            cont_q      <= bus.continuous_capture_frame;
        end
    end

    // Dwell timer: restarts on every state change and runs only in the waiting states.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt_q <= '0;
        end else if (state_d != state_q || !timed) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Frame statistics. Dropped frames are start-of-frames seen in continuous mode
    // outside WAIT_SOF. The drop count saturates at its maximum.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_q <= '0;
            cap_q  <= '0;
        end else begin
            cap_q <= cap_q + {31'd0, done_acc};
            if (sof && bus.continuous_capture_frame && state_q != S_WAIT_SOF &&
                drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    // FPS window: a free-running cycle counter. At the last cycle of each window it
    // publishes the number of completed frames, including one that completes on that cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_q <= '0;
            win_q <= '0;
            fps_q <= '0;
        end else if (cyc_q == FPS_LAST) begin
            cyc_q <= '0;
            win_q <= '0;
            fps_q <= win_q + {31'd0, done_acc};
        end else begin
            cyc_q <= cyc_q + 32'd1;
            win_q <= win_q + {31'd0, done_acc};
        end
    end

    assign bus.dma_start         = dma_start_q;
    assign bus.frame_gate        = gate_q;
    assign bus.capture_busy      = busy_q;
    assign bus.timeout_err       = err_q;
    assign bus.frames_per_second = fps_q;
    assign bus.frames_captured   = cap_q;
    assign bus.capture_status    = {drop_q, 8'd0, gate_q, cont_q, err_q, pend_q, 1'b0, state_q};

endmodule

// File: doc/cam_capture_sched.md
Name: cam_capture_sched

Overview:
- Frame capture scheduler between the camera APB3 control registers and the camera-to-DDR DMA datapath.
- Turns the single-shot and continuous capture controls into per-frame sequencing:
  - hands one DMA descriptor start per frame;
  - gates pixels from start-of-frame to end-of-frame;
  - waits for DMA completion.
- Produces the frames_per_second, status and drop-count words read back over APB.

Parameters:
- CLK_FREQ_HZ, 100000000, clk cycles per one-second FPS measurement window.
- TIMEOUT_CYC, 16777215, max cycles spent in WAIT_SOF, CAPTURE or WAIT_DMA before abort.
- TO_WIDTH, 24, width of timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- resetn  in  1  async active-low reset.
- cam_confdone  in  1  sensor configured (register level).
- cam_dma_init_done  in  1  DMA initialised (register level).
- trigger_capture_frame  in  1  single-shot request; rising edge is significant.
- continuous_capture_frame  in  1  level; capture every frame while high.
- cam_vsync  in  1  frame-start level, synchronous to clk.
- cam_frame_end  in  1  one-cycle end-of-frame pulse from pixel path.
- dma_start  out  1  request to DMA to arm one frame transfer.
- dma_ready  in  1  DMA accepts dma_start.
- dma_done  in  1  one-cycle frame-transfer-complete pulse.
- frame_gate  out  1  high while pixels may enter DMA FIFO.
- capture_busy  out  1  state not in DISABLED or IDLE.
- timeout_err  out  1  sticky timeout flag.
- frames_per_second  out  32  completed frames in last full window.
- frames_captured  out  32  total completed frames, wrapping.
- capture_status  out  32  debug status word.

Behaviour:
- Reset clk/resetn: resetn asynchronous, active-low; clk rising edge. All outputs are registered.
- Reset values: all outputs 0, including frames_per_second and frames_captured. State DISABLED, trigger pending 0, vsync_d 0.
- Edge detection: trig_rise = trigger & ~trig_d; sof = cam_vsync & ~vsync_d. One register stage each.
- trig_rise sets pending, single depth; further edges while pending are absorbed. trig_rise also clears timeout_err.
- FSM states, encoding: DISABLED 0, IDLE 1, ARM 2, WAIT_SOF 3, CAPTURE 4, WAIT_DMA 5.
- Any state except DISABLED: if !(cam_confdone & cam_dma_init_done), go to DISABLED next cycle. This deasserts frame_gate and dma_start and clears pending. Counters are kept. This has highest priority.
- DISABLED: go to IDLE when both enables are high.
- IDLE: go to ARM if pending or continuous; clear pending on entry to ARM.
- ARM: dma_start=1. Transfer occurs in the cycle dma_start & dma_ready; then go to WAIT_SOF and dma_start=0 next cycle. No timeout in ARM.
- WAIT_SOF: on sof, go to CAPTURE; frame_gate=1 from the next cycle. Latency is 1 cycle from the sampled vsync rise.
- CAPTURE: on cam_frame_end, frame_gate=0 next cycle and go to WAIT_DMA.
- WAIT_DMA: on dma_done, frames_captured+1 (wraps at 2^32), window count+1.
  - Next state is ARM if continuous or pending (clear pending), else IDLE.
- Continuous dropped mid-frame: the current frame completes normally, then IDLE.
- Drop counting: frames_dropped is 16-bit, saturating at 0xFFFF. It increments on sof when continuous=1 and state is not WAIT_SOF. This includes sof coincident with cam_frame_end in CAPTURE.
- Timeout: the counter clears on entry to WAIT_SOF/CAPTURE/WAIT_DMA and on each state change.
  - On reaching TIMEOUT_CYC: set timeout_err, go to IDLE, frame_gate=0, clear pending.
- FPS window: the cycle counter runs continuously, 0..CLK_FREQ_HZ-1.
  - At terminal count: frames_per_second <= window count, plus 1 if dma_done is accepted that cycle. Window count then restarts at 0.
- capture_status fields:
  - [2:0] state;
  - [4] pending;
  - [5] timeout_err;
  - [6] continuous;
  - [7] frame_gate;
  - [31:16] frames_dropped;
  - other bits 0.

Test Plan:
- Reset, then confdone=1, dma_init_done=1 -> IDLE in 1 cycle; all outputs 0; capture_status[2:0]=1.
- Single-shot: trigger 0->1, dma_ready=1, vsync rise, frame_end after 100 cycles, dma_done -> exactly one dma_start handshake; frame_gate high for 100 cycles starting 1 cycle after sof; frames_captured=1; back to IDLE.
- Continuous, 3 frames, dma_ready stalled 20 cycles on frame 2 -> dma_start held until dma_ready; frames_captured=3; vsync rise during WAIT_DMA gives frames_dropped=1.
- Timeout with TIMEOUT_CYC=50: arm, no vsync -> timeout_err=1 at cycle 50 after WAIT_SOF entry; state IDLE. Next trigger edge clears it.
- FPS with CLK_FREQ_HZ=1000: continuous frames every 200 cycles -> frames_per_second=5 after the second window. dma_done on a terminal-count cycle is included.
- Mid-capture abort: drop cam_confdone while in CAPTURE -> next cycle DISABLED, frame_gate=0, pending=0, frames_captured unchanged.
